// File: rtl/nvm_writer_if.sv
// nvm_writer_if: byte-write request side and 16-bit memory side of nvm_writer.
// Revision: 1.0
`default_nettype none

interface nvm_writer_if #(
    parameter int WADDR_W = 12
);
    logic               wr_valid;
    logic               wr_ready;
    logic [15:0]        wr_addr;
    logic [7:0]         wr_data;
    logic               flush;
    logic               flush_done;
    logic               busy;
    logic [WADDR_W-1:0] mem_addr;
    logic               mem_rd;
    logic [15:0]        mem_rdata;
    logic               mem_we;
    logic [15:0]        mem_wdata;

    modport master (
        output wr_valid, wr_addr, wr_data, flush, mem_rdata,
        input  wr_ready, flush_done, busy, mem_addr, mem_rd, mem_we, mem_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, flush, mem_rdata,
        output wr_ready, flush_done, busy, mem_addr, mem_rd, mem_we, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/nvm_writer.sv
// nvm_writer: byte writes merged into a one-word read-modify-write buffer over 16-bit NVM.
// Revision: 1.0
`default_nettype none

module nvm_writer #(
    parameter int WADDR_W = 12
) (
    input  wire logic   clk,
    input  wire logic   rst,
    nvm_writer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB    = 3'd1,
        S_FILL  = 3'd2,
        S_FWAIT = 3'd3,
        S_FWB   = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_buf_valid, r_buf_dirty;
    logic [WADDR_W-1:0] r_buf_tag;
    logic [15:0]        r_buf_word;
    logic [WADDR_W-1:0] r_pend_tag;
    logic               r_pend_lane;
    logic [7:0]         r_pend_data;
    logic               r_flush_pend, r_flush_done;

    logic               w_flush_req, w_ready, w_accept, w_hit;
    logic [WADDR_W-1:0] w_wr_tag;
    logic               w_mem_rd, w_mem_we;
    logic [WADDR_W-1:0] w_mem_addr;
    logic [15:0]        w_mem_wdata;
    logic               w_unused_addr;

    function automatic logic [15:0] merge_byte(input logic [15:0] word, input logic lane,
                                               input logic [7:0] data);
        merge_byte = lane ? {data, word[7:0]} : {word[15:8], data};
    endfunction

    // Upper byte-address bits alias onto the same word.
    assign w_unused_addr = ^bus.wr_addr[15:WADDR_W+1];

    assign w_wr_tag    = bus.wr_addr[WADDR_W:1];
    assign w_flush_req = r_flush_pend | bus.flush;
    assign w_ready     = !rst && (r_state == S_IDLE) && !w_flush_req;
    assign w_accept    = bus.wr_valid && w_ready;
    assign w_hit       = r_buf_valid && (r_buf_tag == w_wr_tag);

    always_comb begin
        w_state_nxt = r_state;
        w_mem_rd    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_flush_req) begin
                    if (r_buf_dirty) w_state_nxt = S_FWB;
                end else if (w_accept && !w_hit) begin
                    w_state_nxt = r_buf_dirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_buf_tag;
                w_mem_wdata = r_buf_word;
                w_state_nxt = S_FILL;
            end
            S_FILL: begin
                w_mem_rd    = 1'b1;
                w_mem_addr  = r_pend_tag;
                w_state_nxt = S_FWAIT;
            end
            S_FWAIT: w_state_nxt = S_IDLE;
            S_FWB: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_buf_tag;
                w_mem_wdata = r_buf_word;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_buf_valid  <= 1'b0;
            r_buf_dirty  <= 1'b0;
            r_buf_tag    <= '0;
            r_buf_word   <= '0;
            r_pend_tag   <= '0;
            r_pend_lane  <= 1'b0;
            r_pend_data  <= '0;
            r_flush_pend <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_flush_req) begin
                        // A clean buffer completes the flush without touching memory.
                        r_flush_pend <= r_buf_dirty;
                        r_flush_done <= !r_buf_dirty;
                    end else begin
                        r_flush_pend <= 1'b0;
                        if (w_accept) begin
                            if (w_hit) begin
                                r_buf_word  <= merge_byte(r_buf_word, bus.wr_addr[0], bus.wr_data);
                                r_buf_dirty <= 1'b1;
                            end else begin
                                r_pend_tag  <= w_wr_tag;
                                r_pend_lane <= bus.wr_addr[0];
                                r_pend_data <= bus.wr_data;
                            end
                        end
                    end
                end
                S_FWAIT: begin
                    r_buf_word   <= merge_byte(bus.mem_rdata, r_pend_lane, r_pend_data);
                    r_buf_tag    <= r_pend_tag;
                    r_buf_valid  <= 1'b1;
                    r_buf_dirty  <= 1'b1;
                    r_flush_pend <= r_flush_pend | bus.flush;
                end
                S_FWB: begin
                    // A flush arriving during the write-back is a new request.
                    r_buf_dirty  <= 1'b0;
                    r_flush_done <= 1'b1;
                    r_flush_pend <= bus.flush;
                end
                default: r_flush_pend <= r_flush_pend | bus.flush;
            endcase
        end
    end

    assign bus.wr_ready   = w_ready;
    assign bus.busy       = !rst && ((r_state != S_IDLE) || r_flush_pend);
    assign bus.flush_done = !rst && r_flush_done;
    assign bus.mem_rd     = !rst && w_mem_rd;
    assign bus.mem_we     = !rst && w_mem_we;
    assign bus.mem_addr   = rst ? '0 : w_mem_addr;
    assign bus.mem_wdata  = rst ? '0 : w_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_nvm_writer.sv
// tb_nvm_writer: directed scenarios plus random traffic checked against a transaction-level model.
// Revision: 1.0
`default_nettype none

module tb_nvm_writer;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    nvm_writer_if #(.WADDR_W(12)) bus();

    nvm_writer #(.WADDR_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_word(input int i);
        logic [15:0] w;
        w = 16'(i * 40503) ^ 16'h5A5A;
        if (i == 12'h800) w = 16'h1234;
        if (i == 12'h001) w = 16'hBEEF;
        if (i == 12'h008) w = 16'hC0DE;
        return w;
    endfunction

    function automatic logic [15:0] put_byte(input logic [15:0] w, input logic lane,
                                             input logic [7:0] d);
        return lane ? {d, w[7:0]} : {w[15:8], d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Memory behind the block: registered read, 1-cycle latency.
    logic [15:0] mem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        end
    end

    // Reference model: a queue of per-cycle memory operations planned at accept/flush time.
    typedef struct packed {
        logic        rd;
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [1:0]  act;   // 1: fill completes, 2: flush write-back completes
    } op_t;

    op_t         plan[$];
    logic [15:0] shadow [0:4095];
    logic        m_valid, m_dirty, m_pend, m_done;
    logic [11:0] m_tag, p_tag;
    logic [15:0] m_word;
    logic        p_lane;
    logic [7:0]  p_data;

    initial begin : cmp
        op_t         cur;
        logic        e_ready, e_busy, e_done, nxt_done;
        logic [11:0] t;
        for (int i = 0; i < 4096; i++) shadow[i] = init_word(i);
        m_valid = 0; m_dirty = 0; m_pend = 0; m_done = 0;
        m_tag = 0; m_word = 0; p_tag = 0; p_lane = 0; p_data = 0;
        forever begin
            @(negedge clk);
            cur = (plan.size() > 0) ? plan[0] : '0;
            if (rst) begin
                cur = '0; e_ready = 0; e_busy = 0; e_done = 0;
            end else begin
                e_ready = (plan.size() == 0) && !m_pend && !bus.flush;
                e_busy  = (plan.size() != 0) || m_pend;
                e_done  = m_done;
            end
            chk("wr_ready",   bus.wr_ready,   e_ready);
            chk("busy",       bus.busy,       e_busy);
            chk("flush_done", bus.flush_done, e_done);
            chk("mem_rd",     bus.mem_rd,     cur.rd);
            chk("mem_we",     bus.mem_we,     cur.we);
            chk("mem_addr",   bus.mem_addr,   cur.addr);
            chk("mem_wdata",  bus.mem_wdata,  cur.wdata);

            if (rst) begin
                plan.delete();
                m_valid = 0; m_dirty = 0; m_pend = 0; m_done = 0;
            end else begin
                nxt_done = 0;
                if (plan.size() > 0) begin
                    void'(plan.pop_front());
                    if (cur.we) shadow[cur.addr] = cur.wdata;
                    if (cur.act == 2'd2) begin
                        m_dirty = 0; nxt_done = 1; m_pend = bus.flush;
                    end else begin
                        m_pend = m_pend | bus.flush;
                        if (cur.act == 2'd1) begin
                            m_word = put_byte(shadow[p_tag], p_lane, p_data);
                            m_tag = p_tag; m_valid = 1; m_dirty = 1;
                        end
                    end
                end else if (m_pend || bus.flush) begin
                    if (m_dirty) begin
                        plan.push_back('{rd:1'b0, we:1'b1, addr:m_tag, wdata:m_word, act:2'd2});
                        m_pend = 1;
                    end else begin
                        m_pend = 0; nxt_done = 1;
                    end
                end else if (bus.wr_valid) begin
                    t = bus.wr_addr[12:1];
                    if (m_valid && t == m_tag) begin
                        m_word  = put_byte(m_word, bus.wr_addr[0], bus.wr_data);
                        m_dirty = 1;
                    end else begin
                        p_tag = t; p_lane = bus.wr_addr[0]; p_data = bus.wr_data;
                        if (m_dirty)
                            plan.push_back('{rd:1'b0, we:1'b1, addr:m_tag, wdata:m_word, act:2'd0});
                        plan.push_back('{rd:1'b1, we:1'b0, addr:t, wdata:16'h0, act:2'd0});
                        plan.push_back('{rd:1'b0, we:1'b0, addr:12'h0, wdata:16'h0, act:2'd1});
                    end
                end
                m_done = nxt_done;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that follows acceptance.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, output int ac);
        bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d; ac = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.wr_ready) begin ac = cyc; break; end
        end
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        if (ac < 0) chk("write_timeout", 0, 1);
    endtask

    task automatic do_flush(output int fc, output int dc);
        bus.flush = 1'b1; fc = cyc; dc = -1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.flush_done) begin dc = cyc; break; end
        end
        if (dc < 0) chk("flush_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int c0, c1, c2, c3, c4, c5, fc, dc, ac;
        logic [11:0] tg;
        checks = 0; errors = 0;
        rst = 1'b1;
        bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.flush = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", bus.wr_ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.flush_done, 0);
        @(posedge clk); #1;

        // Miss into an empty buffer, then a hit on the other lane, then flush.
        do_write(16'h1000, 8'hA5, c0);
        @(negedge clk);
        chk("fill_rd", bus.mem_rd, 1);
        chk("fill_addr", bus.mem_addr, 12'h800);
        @(posedge clk); #1;
        do_write(16'h1001, 8'h5A, c1);
        chk("miss_gap", c1 - c0, 3);
        do_flush(fc, dc);
        chk("flush_dirty_lat", dc - fc, 2);
        chk("flush_word800", mem[12'h800], 16'h5AA5);

        // Dirty miss: write-back before the fill.
        do_write(16'h1000, 8'h11, c0);
        do_write(16'h0002, 8'hFF, c2);
        do_write(16'h0003, 8'hEE, c3);
        chk("dirty_miss_gap", c3 - c2, 4);
        chk("wb_word800", mem[12'h800], 16'h5A11);
        do_flush(fc, dc);
        chk("flush_word001", mem[12'h001], 16'hEEFF);

        // Flush and write in the same cycle: flush goes first.
        bus.flush = 1; bus.wr_valid = 1; bus.wr_addr = 16'h0004; bus.wr_data = 8'h33;
        fc = cyc; dc = -1; ac = -1;
        @(negedge clk);
        chk("flush_blocks_wr", bus.wr_ready, 0);
        @(posedge clk); #1;
        bus.flush = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.flush_done) dc = cyc;
            if (bus.wr_ready) begin ac = cyc; break; end
        end
        @(posedge clk); #1;
        bus.wr_valid = 0;
        chk("flush_clean_lat", dc - fc, 1);
        chk("wr_after_done", (ac >= dc) && (dc > 0), 1);

        // Aliased address 0xE003 hits word 0x001, upper lane; word 0x002 written back first.
        do_write(16'hE003, 8'h77, c4);
        @(negedge clk);
        chk("alias_wb_we", bus.mem_we, 1);
        chk("alias_wb_addr", bus.mem_addr, 12'h002);
        @(negedge clk);
        chk("alias_rd_addr", bus.mem_addr, 12'h001);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset during FWAIT discards the newly merged dirty word.
        do_write(16'h0010, 8'h99, c5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_rd", bus.mem_rd, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.wr_ready, 1);
        chk("post_rst_busy", bus.busy, 0);
        chk("alias_word001", mem[12'h001], 16'h77FF);
        @(posedge clk); #1;
        do_flush(fc, dc);
        chk("post_rst_flush_lat", dc - fc, 1);
        chk("discarded_word008", mem[12'h008], 16'hC0DE);

        // Random traffic over a few hot words plus scattered ones.
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            bus.flush    = ($urandom_range(0, 24) == 0);
            bus.wr_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       tg = 12'h800;
                1:       tg = 12'h001;
                2:       tg = 12'h002;
                default: tg = 12'($urandom);
            endcase
            bus.wr_addr = {3'($urandom), tg, 1'($urandom)};
            bus.wr_data = 8'($urandom);
            @(posedge clk); #1;
        end
        rst = 0; bus.flush = 0; bus.wr_valid = 0;
        repeat (10) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
